load_store_unit_v2: RTL and testbench
=====================================

Name: load_store_unit_v2

Overview:
Parametrised, handshaked successor to the core's load/store unit. It accepts one load/store request at a time from the MEMEX stage and decodes it against a configurable address map: DTCM, ITCM and an MMIO window for peripherals such as SPI and the seven-segment display. It adds per-lane byte strobes, alignment and unmapped-address faults, and a variable-latency MMIO req/ack handshake with a timeout. It returns a single response pulse carrying load data that is already lane-extracted and sign- or zero-extended.

Parameters:
DTCM_BASE, 32'h1000, DTCM window base (byte address)
DTCM_SIZE, 32'h4000, DTCM window size in bytes (power of two)
ITCM_BASE, 32'h5000, ITCM window base
ITCM_SIZE, 32'h4000, ITCM window size
MMIO_BASE, 32'h0000, MMIO window base
MMIO_SIZE, 32'h1000, MMIO window size
TIMEOUT, 15, max cycles waiting for mmio_ack (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_sign_extend  in  1  sign-extend load result
req_width  in  2  0=byte, 1=half, 2=word, 3=illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result (0 for stores and faults)
rsp_fault  out  2  0=ok, 1=misaligned/illegal width, 2=unmapped, 3=timeout
dtcm_we / itcm_we  out  1  TCM write enable
dtcm_be / itcm_be  out  4  TCM byte enables
tcm_addr  out  32  address offset within the selected TCM window (shared by both TCMs)
tcm_wdata  out  32  lane-replicated store data (shared)
dtcm_rdata / itcm_rdata  in  32  TCM read data, valid 1 cycle after address
mmio_req  out  1  MMIO request, held until ack
mmio_we  out  1  MMIO write
mmio_addr  out  32  offset within the MMIO window
mmio_be  out  4  MMIO byte enables
mmio_wdata  out  32  lane-replicated store data
mmio_ack  in  1  peripheral completion
mmio_rdata  in  32  valid when mmio_ack=1

Behaviour:
- FSM states: IDLE, TCM_RD, MMIO_WAIT, RESP.
- req_ready=1 only in IDLE.
- Reset: state=IDLE. rsp_valid, rsp_rdata, rsp_fault, mmio_req, mmio_we, *_we and *_be all reset to 0. The timeout counter resets to 0.
- Reset mid-operation: the transaction is abandoned, mmio_req drops the next cycle, and no response is emitted.
- Decode at accept: window hit is base <= addr < base+size. Fault precedence is misaligned/illegal width first, then unmapped.
- Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or width=3.
- Faulted request: no memory side effect. Go to RESP with the fault code; rsp_valid is asserted the next cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Write data replication: byte data {4{wdata[7:0]}}, half data {2{wdata[15:0]}}.
- TCM store: *_we and *_be are driven combinationally in the accept cycle (IDLE && req_valid). rsp_valid is asserted the next cycle with fault 0. Latency 1.
- TCM load: address is driven in the accept cycle; *_we=0, *_be=0. TCM_RD captures rdata the next cycle, extracts and extends it, and asserts rsp_valid the cycle after. Latency 2.
- MMIO access: mmio_req, mmio_we, mmio_addr, mmio_be and mmio_wdata are registered at accept and held stable in MMIO_WAIT until mmio_ack.
  - Counter increments each cycle in MMIO_WAIT.
  - mmio_ack: drop mmio_req; capture rdata for loads; go to RESP with fault 0.
  - Counter reaches TIMEOUT without ack: drop mmio_req; go to RESP with fault 3 and rdata 0.
  - ack in the same cycle as timeout: ack wins.
  - ack while not in MMIO_WAIT is ignored.
- Load extraction: shift right by addr[1:0]*8 (using the captured address), then mask to the width. Sign-extend from bit 7 or 15 when req_sign_extend=1, otherwise zero-extend. Word loads pass through unchanged.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- rsp_rdata and rsp_fault hold their values until the next response.
- Address offsets are addr minus window base; no wrap-around. An address at base+size is unmapped.

Test Plan:
- Store byte 8'hA5 to 0x1003, then load byte sign-extended -> dtcm_be=4'b1000, tcm_wdata=32'hA5A5A5A5; load returns 32'hFFFFFFA5 two cycles after accept with fault 0.
- Load half from 0x5002 with itcm_rdata=32'h80011234, unsigned -> 32'h00008001; signed -> 32'hFFFF8001.
- Word load at 0x1001 and width=3 at 0x1000 -> fault 1 next cycle; no *_we or mmio_req pulse. Load at 0x9000 -> fault 2.
- MMIO word store to 0x804 with ack after 3 cycles -> mmio_req high 3 cycles with stable mmio_addr=0x804 and be=4'hF; rsp_valid the cycle after ack, fault 0.
- MMIO load with no ack, TIMEOUT=15 -> mmio_req drops after 15 cycles; fault 3, rdata 0. A repeat with ack on exactly cycle 15 -> fault 0.
- rst asserted during MMIO_WAIT -> mmio_req=0 the next cycle, no rsp_valid, req_ready=1; a following DTCM load completes normally.

Source files
------------

// File: rtl/load_store_unit_v2.sv
// Load/store unit: decodes one request at a time against DTCM, ITCM and MMIO
// windows, drives TCM strobes in the accept cycle, runs a req/ack handshake
// with timeout for MMIO, and returns a single-cycle response with extended
// load data and a fault code.
module load_store_unit_v2 #(
    parameter logic [31:0] DTCM_BASE = 32'h1000,
    parameter logic [31:0] DTCM_SIZE = 32'h4000,
    parameter logic [31:0] ITCM_BASE = 32'h5000,
    parameter logic [31:0] ITCM_SIZE = 32'h4000,
    parameter logic [31:0] MMIO_BASE = 32'h0000,
    parameter logic [31:0] MMIO_SIZE = 32'h1000,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    // Request handshake: a request transfers on a cycle where req_valid and
    // req_ready are both 1. The requester keeps its fields stable while
    // req_valid=1 and req_ready=0. req_ready is 1 only in IDLE (and not in
    // reset). There is no response backpressure: rsp_valid is a one-cycle
    // pulse that the requester must take when it appears.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_sign_extend,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic        dtcm_we,
    output logic [3:0]  dtcm_be,
    output logic        itcm_we,
    output logic [3:0]  itcm_be,
    output logic [31:0] tcm_addr,
    output logic [31:0] tcm_wdata,
    input  logic [31:0] dtcm_rdata,
    input  logic [31:0] itcm_rdata,
    output logic        mmio_req,
    output logic        mmio_we,
    output logic [31:0] mmio_addr,
    output logic [3:0]  mmio_be,
    output logic [31:0] mmio_wdata,
    input  logic        mmio_ack,
    input  logic [31:0] mmio_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TCM_RD    = 2'd1,
        MMIO_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  cap_lane;
    logic [1:0]  cap_width;
    logic        cap_sign;
    logic        cap_we;
    logic        cap_itcm;

    logic        accept;
    logic        misaligned;
    logic        hit_dtcm;
    logic        hit_itcm;
    logic        hit_mmio;
    logic [1:0]  fault_dec;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    // Window hit: base <= a < base+size, written without forming base+size
    // so a window touching the top of the address space cannot wrap.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (a >= base) && ((a - base) < size);
    endfunction

    // Move the addressed lane to bit 0, then sign- or zero-extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] data,
                                            input logic [1:0]  lane,
                                            input logic [1:0]  width,
                                            input logic        sx);
        logic [31:0] shifted;
        shifted = data >> {lane, 3'b000};
        case (width)
            2'd0:    return sx ? {{24{shifted[7]}}, shifted[7:0]}
                               : {24'h0, shifted[7:0]};
            2'd1:    return sx ? {{16{shifted[15]}}, shifted[15:0]}
                               : {16'h0, shifted[15:0]};
            default: return data;
        endcase
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_ready && req_valid;
    assign state_dbg = state;

    // Request decode: alignment, window selection (DTCM > ITCM > MMIO if
    // windows overlap), fault priority, byte enables and lane replication.
    always_comb begin
        misaligned = (req_width == 2'd3)
                  || ((req_width == 2'd1) && req_addr[0])
                  || ((req_width == 2'd2) && (req_addr[1:0] != 2'b00));
        hit_dtcm = in_window(req_addr, DTCM_BASE, DTCM_SIZE);
        hit_itcm = !hit_dtcm && in_window(req_addr, ITCM_BASE, ITCM_SIZE);
        hit_mmio = !hit_dtcm && !hit_itcm && in_window(req_addr, MMIO_BASE, MMIO_SIZE);
        if (misaligned)
            fault_dec = 2'd1;
        else if (!(hit_dtcm || hit_itcm || hit_mmio))
            fault_dec = 2'd2;
        else
            fault_dec = 2'd0;
        case (req_width)
            2'd0:    be = 4'b0001 << req_addr[1:0];
            2'd1:    be = 4'b0011 << {req_addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
        case (req_width)
            2'd0:    wdata_rep = {4{req_wdata[7:0]}};
            2'd1:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    // TCM address and data are shared; only the strobes are per memory.
    assign tcm_addr  = hit_itcm ? (req_addr - ITCM_BASE) : (req_addr - DTCM_BASE);
    assign tcm_wdata = wdata_rep;

    // TCM stores write in the accept cycle; loads and faults never strobe.
    always_comb begin
        dtcm_we = 1'b0;
        itcm_we = 1'b0;
        dtcm_be = 4'b0000;
        itcm_be = 4'b0000;
        if (accept && (fault_dec == 2'd0) && req_we) begin
            if (hit_dtcm) begin
                dtcm_we = 1'b1;
                dtcm_be = be;
            end else if (hit_itcm) begin
                itcm_we = 1'b1;
                itcm_be = be;
            end
        end
    end

    // Transaction FSM with registered response and MMIO outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_fault  <= 2'd0;
            mmio_req   <= 1'b0;
            mmio_we    <= 1'b0;
            mmio_addr  <= 32'h0;
            mmio_be    <= 4'b0000;
            mmio_wdata <= 32'h0;
            wait_cnt   <= 8'd0;
            cap_lane   <= 2'd0;
            cap_width  <= 2'd0;
            cap_sign   <= 1'b0;
            cap_we     <= 1'b0;
            cap_itcm   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_lane  <= req_addr[1:0];
                        cap_width <= req_width;
                        cap_sign  <= req_sign_extend;
                        cap_we    <= req_we;
                        cap_itcm  <= hit_itcm;
                        if (fault_dec != 2'd0) begin
                            rsp_fault <= fault_dec;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (hit_mmio) begin
                            mmio_req   <= 1'b1;
                            mmio_we    <= req_we;
                            mmio_addr  <= req_addr - MMIO_BASE;
                            mmio_be    <= be;
                            mmio_wdata <= wdata_rep;
                            wait_cnt   <= 8'd0;
                            state      <= MMIO_WAIT;
                        end else if (req_we) begin
                            rsp_fault <= 2'd0;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= TCM_RD;
                        end
                    end
                end
                TCM_RD: begin
                    rsp_rdata <= extract(cap_itcm ? itcm_rdata : dtcm_rdata,
                                         cap_lane, cap_width, cap_sign);
                    rsp_fault <= 2'd0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                MMIO_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // Ack is checked first so an ack on the last allowed
                    // cycle completes normally instead of timing out.
                    if (mmio_ack) begin
                        mmio_req  <= 1'b0;
                        mmio_we   <= 1'b0;
                        mmio_be   <= 4'b0000;
                        rsp_rdata <= cap_we ? 32'h0
                                            : extract(mmio_rdata, cap_lane, cap_width, cap_sign);
                        rsp_fault <= 2'd0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == TIMEOUT_M1) begin
                        mmio_req  <= 1'b0;
                        mmio_we   <= 1'b0;
                        mmio_be   <= 4'b0000;
                        rsp_rdata <= 32'h0;
                        rsp_fault <= 2'd3;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit_v2.sv
// Bench for load_store_unit_v2: vector table for TCM and fault cases,
// hand-written MMIO handshake / timeout / reset sequences, random TCM loads.
module tb_load_store_unit_v2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_sign_extend;
    logic [1:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic        dtcm_we;
    logic [3:0]  dtcm_be;
    logic        itcm_we;
    logic [3:0]  itcm_be;
    logic [31:0] tcm_addr;
    logic [31:0] tcm_wdata;
    logic [31:0] dtcm_rdata;
    logic [31:0] itcm_rdata;
    logic        mmio_req;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [3:0]  mmio_be;
    logic [31:0] mmio_wdata;
    logic        mmio_ack;
    logic [31:0] mmio_rdata;
    logic [1:0]  state_dbg;

    int checks;
    int failures;
    logic [33:0] exp_q[$];   // {fault, rdata}

    typedef struct {
        string       name;
        logic        we;
        logic        sx;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_d;
        logic [31:0] rd_i;
        logic [3:0]  dbe;
        logic [3:0]  ibe;
        logic [31:0] twd;
        logic [31:0] taddr;
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    load_store_unit_v2 dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sign_extend(req_sign_extend), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .dtcm_we(dtcm_we), .dtcm_be(dtcm_be), .itcm_we(itcm_we), .itcm_be(itcm_be),
        .tcm_addr(tcm_addr), .tcm_wdata(tcm_wdata),
        .dtcm_rdata(dtcm_rdata), .itcm_rdata(itcm_rdata),
        .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_be(mmio_be), .mmio_wdata(mmio_wdata),
        .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata),
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something wedges
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Pop the oldest expected response and compare it with the DUT outputs
    task automatic sb_pop(input string name);
        logic [33:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected response: actual rdata=%h fault=%0d expected=none",
                     name, rsp_rdata, rsp_fault);
        end else begin
            checks--;
            e = exp_q.pop_front();
            check({name, " rdata"}, rsp_rdata, e[31:0]);
            check({name, " fault"}, {30'h0, rsp_fault}, {30'h0, e[33:32]});
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic sx,
                                input logic [1:0] width, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd_d,
                                input logic [31:0] rd_i, input logic [3:0] dbe,
                                input logic [3:0] ibe, input logic [31:0] twd,
                                input logic [31:0] taddr, input logic [31:0] rdata,
                                input logic [1:0] fault, input int lat);
        vec_t v;
        v.name = name; v.we = we; v.sx = sx; v.width = width; v.addr = addr;
        v.wdata = wdata; v.rd_d = rd_d; v.rd_i = rd_i; v.dbe = dbe; v.ibe = ibe;
        v.twd = twd; v.taddr = taddr; v.rdata = rdata; v.fault = fault; v.lat = lat;
        return v;
    endfunction

    // Independent reference for load extraction
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [1:0] width, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[lane*8 +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        if (width == 2'd0) return sx && b[7] ? {24'hFFFFFF, b} : {24'h0, b};
        if (width == 2'd1) return sx && h[15] ? {16'hFFFF, h} : {16'h0, h};
        return rd;
    endfunction

    // Driver for one TCM / fault request, with latency and pulse checks
    task automatic run_vec(input vec_t v);
        int lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = v.we; req_sign_extend = v.sx; req_width = v.width;
        req_addr = v.addr; req_wdata = v.wdata;
        dtcm_rdata = ~v.rd_d; itcm_rdata = ~v.rd_i;
        @(negedge clk);
        check({v.name, " req_ready"}, {31'h0, req_ready}, 32'h1);
        check({v.name, " dtcm_be"}, {28'h0, dtcm_be}, {28'h0, v.dbe});
        check({v.name, " itcm_be"}, {28'h0, itcm_be}, {28'h0, v.ibe});
        check({v.name, " dtcm_we"}, {31'h0, dtcm_we}, {31'h0, (v.dbe != 4'h0)});
        check({v.name, " itcm_we"}, {31'h0, itcm_we}, {31'h0, (v.ibe != 4'h0)});
        if (v.fault == 2'd0) check({v.name, " tcm_addr"}, tcm_addr, v.taddr);
        if (v.we && v.fault == 2'd0) check({v.name, " tcm_wdata"}, tcm_wdata, v.twd);
        exp_q.push_back({v.fault, v.rdata});
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_width = 2'($urandom_range(0, 3));
        dtcm_rdata = v.rd_d; itcm_rdata = v.rd_i;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check({v.name, " mmio_req"}, {31'h0, mmio_req}, 32'h0);
                check({v.name, " we after accept"}, {30'h0, dtcm_we, itcm_we}, 32'h0);
            end
            if (rsp_valid) begin
                lat = i;
                sb_pop(v.name);
                break;
            end
        end
        check({v.name, " latency"}, lat, v.lat);
        if (lat == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        check({v.name, " pulse width"}, {31'h0, rsp_valid}, 32'h0);
        check({v.name, " rdata hold"}, rsp_rdata, v.rdata);
    endtask

    // Driver for one MMIO request; ack_at=0 means never acknowledge
    task automatic run_mmio(input string name, input logic we, input logic sx,
                            input logic [1:0] width, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] ack_rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                            input logic [1:0] exp_fault, input int exp_cycles);
        int  req_cnt;
        bit  done;
        @(posedge clk); #1;
        mmio_ack = 1'b0;
        req_valid = 1'b1; req_we = we; req_sign_extend = sx; req_width = width;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        check({name, " req_ready"}, {31'h0, req_ready}, 32'h1);
        check({name, " tcm we"}, {30'h0, dtcm_we, itcm_we}, 32'h0);
        exp_q.push_back({exp_fault, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_cnt = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            mmio_ack = (k == ack_at);
            mmio_rdata = (k == ack_at) ? ack_rdata : $urandom;
            @(negedge clk);
            if (mmio_req) begin
                req_cnt++;
                check({name, " mmio_addr"}, mmio_addr, addr);
                check({name, " mmio_be"}, {28'h0, mmio_be}, {28'h0, exp_be});
                check({name, " mmio_we"}, {31'h0, mmio_we}, {31'h0, we});
                if (we) check({name, " mmio_wdata"}, mmio_wdata, exp_wdata);
                check({name, " ready in wait"}, {31'h0, req_ready}, 32'h0);
            end else begin
                check({name, " rsp_valid after req"}, {31'h0, rsp_valid}, 32'h1);
                if (rsp_valid) sb_pop(name);
                else if (exp_q.size() > 0) void'(exp_q.pop_front());
                done = 1;
            end
            @(posedge clk); #1;
        end
        mmio_ack = 1'b0;
        check({name, " mmio_req cycles"}, req_cnt, exp_cycles);
    endtask

    initial begin
        int pulses;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_sign_extend = 1'b0; req_width = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        dtcm_rdata = 32'h0; itcm_rdata = 32'h0; mmio_ack = 1'b0; mmio_rdata = 32'h0;

        vecs[0]  = mk("st_b_1003", 1, 0, 2'd0, 32'h1003, 32'h000000A5, 32'h0, 32'h0,
                      4'b1000, 4'b0000, 32'hA5A5A5A5, 32'h3, 32'h0, 2'd0, 1);
        vecs[1]  = mk("ld_bs_1003", 0, 1, 2'd0, 32'h1003, 32'h0, 32'hA5123456, 32'h5A5A5A5A,
                      4'b0000, 4'b0000, 32'h0, 32'h3, 32'hFFFFFFA5, 2'd0, 2);
        vecs[2]  = mk("ld_hu_5002", 0, 0, 2'd1, 32'h5002, 32'h0, 32'hDEADBEEF, 32'h80011234,
                      4'b0000, 4'b0000, 32'h0, 32'h2, 32'h00008001, 2'd0, 2);
        vecs[3]  = mk("ld_hs_5002", 0, 1, 2'd1, 32'h5002, 32'h0, 32'hDEADBEEF, 32'h80011234,
                      4'b0000, 4'b0000, 32'h0, 32'h2, 32'hFFFF8001, 2'd0, 2);
        vecs[4]  = mk("ld_w_1001", 0, 0, 2'd2, 32'h1001, 32'h0, 32'h11111111, 32'h22222222,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd1, 1);
        vecs[5]  = mk("st_w3_1000", 1, 0, 2'd3, 32'h1000, 32'hFFFFFFFF, 32'h0, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd1, 1);
        vecs[6]  = mk("ld_b_9000", 0, 0, 2'd0, 32'h9000, 32'h0, 32'h33333333, 32'h44444444,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd2, 1);
        vecs[7]  = mk("st_h_1006", 1, 0, 2'd1, 32'h1006, 32'h1234BEEF, 32'h0, 32'h0,
                      4'b1100, 4'b0000, 32'hBEEFBEEF, 32'h6, 32'h0, 2'd0, 1);
        vecs[8]  = mk("st_w_8ffc", 1, 0, 2'd2, 32'h8FFC, 32'h12345678, 32'h0, 32'h0,
                      4'b0000, 4'b1111, 32'h12345678, 32'h3FFC, 32'h0, 2'd0, 1);
        vecs[9]  = mk("ld_bu_4fff", 0, 0, 2'd0, 32'h4FFF, 32'h0, 32'h80FFFFFF, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h3FFF, 32'h00000080, 2'd0, 2);
        vecs[10] = mk("ld_bs_1001", 0, 1, 2'd0, 32'h1001, 32'h0, 32'hFFFF7FFF, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h1, 32'h0000007F, 2'd0, 2);
        vecs[11] = mk("st_h_5001", 1, 0, 2'd1, 32'h5001, 32'hFFFF, 32'h0, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd1, 1);
        vecs[12] = mk("ld_w_9001", 0, 0, 2'd2, 32'h9001, 32'h0, 32'h0, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd1, 1);
        vecs[13] = mk("st_w_fffc", 1, 0, 2'd2, 32'hFFFFFFFC, 32'h55AA55AA, 32'h0, 32'h0,
                      4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 2'd2, 1);

        // Reset: present a DTCM store while in reset, nothing may strobe
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000; req_width = 2'd2;
        @(negedge clk);
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_fault", {30'h0, rsp_fault}, 32'h0);
        check("reset mmio_req", {31'h0, mmio_req}, 32'h0);
        check("reset mmio_we/be", {27'h0, mmio_we, mmio_be}, 32'h0);
        check("reset tcm we/be", {22'h0, dtcm_we, itcm_we, dtcm_be, itcm_be}, 32'h0);
        check("reset req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("post-reset req_ready", {31'h0, req_ready}, 32'h1);
        check("post-reset state", {30'h0, state_dbg}, 32'h0);

        // Vector table; ack held high to show it is ignored outside MMIO_WAIT
        mmio_ack = 1'b1;
        mmio_rdata = 32'hBADBAD00;
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);
        mmio_ack = 1'b0;

        // MMIO sequences
        run_mmio("mmio_st_804", 1, 0, 2'd2, 32'h804, 32'hCAFEBABE, 3, 32'h0,
                 4'hF, 32'hCAFEBABE, 32'h0, 2'd0, 3);
        run_mmio("mmio_ld_timeout", 0, 0, 2'd2, 32'h10, 32'h0, 0, 32'h0,
                 4'hF, 32'h0, 32'h0, 2'd3, 15);
        run_mmio("mmio_ld_ack15", 0, 0, 2'd2, 32'h10, 32'h0, 15, 32'hCAFEF00D,
                 4'hF, 32'h0, 32'hCAFEF00D, 2'd0, 15);
        run_mmio("mmio_ld_hs_ffe", 0, 1, 2'd1, 32'hFFE, 32'h0, 1, 32'h9ABC0000,
                 4'b1100, 32'h0, 32'hFFFF9ABC, 2'd0, 1);
        run_mmio("mmio_st_b_3", 1, 0, 2'd0, 32'h3, 32'h0000005C, 2, 32'h0,
                 4'b1000, 32'h5C5C5C5C, 32'h0, 2'd0, 2);

        // Reset during MMIO_WAIT: request drops, no response appears
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'd2; req_addr = 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre-reset mmio_req", {31'h0, mmio_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid-reset mmio_req", {31'h0, mmio_req}, 32'h0);
        check("mid-reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mid-reset req_ready", {31'h0, req_ready}, 32'h1);
        check("mid-reset state", {30'h0, state_dbg}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("mid-reset no response", pulses, 0);
        mmio_ack = 1'b1;
        run_vec(mk("ld_w_after_rst", 0, 0, 2'd2, 32'h1010, 32'h0, 32'h89ABCDEF, 32'h0,
                   4'b0000, 4'b0000, 32'h0, 32'h10, 32'h89ABCDEF, 2'd0, 2));
        mmio_ack = 1'b0;

        // Random aligned TCM loads
        for (int n = 0; n < 16; n++) begin
            logic [1:0]  w;
            logic        sx;
            logic        itcm;
            logic [31:0] off;
            logic [31:0] a;
            logic [31:0] rd;
            w = 2'($urandom_range(0, 2));
            sx = 1'($urandom_range(0, 1));
            itcm = 1'($urandom_range(0, 1));
            off = 32'($urandom_range(0, 32'h3FFF));
            if (w == 2'd2) off[1:0] = 2'b00;
            if (w == 2'd1) off[0] = 1'b0;
            a = (itcm ? 32'h5000 : 32'h1000) + off;
            rd = $urandom;
            run_vec(mk("rand_ld", 0, sx, w, a, 32'h0, itcm ? ~rd : rd, itcm ? rd : ~rd,
                       4'b0000, 4'b0000, 32'h0, off, ref_load(rd, a[1:0], w, sx), 2'd0, 2));
        end

        check("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
